// File: rtl/tc_pkg.sv
// Shared light encodings, phase enum and helpers for the traffic-light monitor.
package tc_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    localparam int YEL_CNT_W = 4;

    typedef enum logic [1:0] {
        S_INIT,
        S_GREEN,
        S_YELLOW,
        S_RED
    } phase_t;

    function automatic logic is_legal_light(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
    endfunction

    // Illegal codes map to S_INIT so the tracker restarts cleanly.
    function automatic phase_t light_to_phase(input logic [2:0] code);
        phase_t ph;
        case (code)
            LIGHT_RED: ph = S_RED;
            LIGHT_YEL: ph = S_YELLOW;
            LIGHT_GRN: ph = S_GREEN;
            default:   ph = S_INIT;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/tc_light_tracker.sv
// Per-street phase tracker: follows the light sequence, times yellow phases,
// counts completed red-to-green cycles and emits one-cycle error pulses.
module tc_light_tracker
    import tc_pkg::*;
#(
    parameter int YELLOW_CYCLES = 5,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [2:0]       sample,
    output phase_t           state,
    output logic [CNT_W-1:0] cycles,
    output logic             seq_err,
    output logic             illegal_err,
    output logic             yel_err
);

    localparam logic [YEL_CNT_W-1:0] YEL_TARGET = YEL_CNT_W'(YELLOW_CYCLES);
    localparam logic [YEL_CNT_W-1:0] YEL_MAX    = '1;

    phase_t                 state_reg, state_next, obs;
    logic [YEL_CNT_W-1:0]   yel_cnt_reg, yel_cnt_next;
    logic [CNT_W-1:0]       cycles_reg, cycles_next;
    logic                   legal, move_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_INIT;
            yel_cnt_reg <= '0;
            cycles_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            yel_cnt_reg <= yel_cnt_next;
            cycles_reg  <= cycles_next;
        end
    end

    always_comb begin
        legal        = is_legal_light(sample);
        obs          = light_to_phase(sample);
        state_next   = state_reg;
        yel_cnt_next = yel_cnt_reg;
        cycles_next  = cycles_reg;
        seq_err      = 1'b0;
        illegal_err  = 1'b0;
        yel_err      = 1'b0;
        move_ok      = 1'b1;

        case (state_reg)
            S_GREEN:  move_ok = (obs == S_GREEN)  || (obs == S_YELLOW);
            S_YELLOW: move_ok = (obs == S_YELLOW) || (obs == S_RED);
            S_RED:    move_ok = (obs == S_RED)    || (obs == S_GREEN);
            default:  move_ok = 1'b1;
        endcase

        if (sample_valid) begin
            if (!legal) begin
                illegal_err = 1'b1;
                yel_err     = (state_reg == S_YELLOW);
                state_next  = S_INIT;
            end else begin
                seq_err = !move_ok;
                if ((state_reg == S_YELLOW) && (obs != S_YELLOW))
                    yel_err = (yel_cnt_reg != YEL_TARGET);
                // The entering sample itself counts as the first yellow cycle.
                if (obs == S_YELLOW) begin
                    if (state_reg != S_YELLOW)
                        yel_cnt_next = YEL_CNT_W'(1);
                    else if (yel_cnt_reg != YEL_MAX)
                        yel_cnt_next = yel_cnt_reg + 1'b1;
                end
                if ((state_reg == S_RED) && (obs == S_GREEN))
                    cycles_next = cycles_reg + 1'b1;
                state_next = obs;
            end
        end
    end

    assign state  = state_reg;
    assign cycles = cycles_reg;

endmodule

// File: rtl/tc_light_monitor.sv
// Passive checker for the traffic-controller light outputs with sticky error flags.
// Optional parade-rule checking is built when TC_LIGHT_MONITOR_PARADE_CHECK_EN is defined.
module tc_light_monitor
    import tc_pkg::*;
#(
    parameter int YELLOW_CYCLES = 5,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [2:0]       L_A,
    input  logic [2:0]       L_B,
    input  logic             P,
    input  logic             R,
    output logic             ERR_ILLEGAL,
    output logic             ERR_SEQ,
    output logic             ERR_CONFLICT,
    output logic             ERR_YEL,
    output logic             ERR_PARADE,
    output logic             ERR_ANY,
    output logic [CNT_W-1:0] CYCLES_A,
    output logic [CNT_W-1:0] CYCLES_B
);

    localparam int NUM_ST = 2;

    logic [2:0]         samp_reg [NUM_ST];
    logic               samp_valid_reg;
    phase_t             st       [NUM_ST];
    logic [CNT_W-1:0]   cyc      [NUM_ST];
    logic [NUM_ST-1:0]  seq_p, ill_p, yel_p;
    logic               conflict_hit, parade_hit;
    logic               err_ill_reg, err_seq_reg, err_conf_reg, err_yel_reg, err_par_reg;

    // Sample stage; the valid bit keeps the first post-reset edge from checking stale data.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            samp_reg[0]    <= '0;
            samp_reg[1]    <= '0;
            samp_valid_reg <= 1'b0;
        end else begin
            samp_reg[0]    <= L_A;
            samp_reg[1]    <= L_B;
            samp_valid_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ST; gi++) begin : g_street
            tc_light_tracker #(
                .YELLOW_CYCLES(YELLOW_CYCLES),
                .CNT_W        (CNT_W)
            ) u_tracker (
                .clk         (CLK),
                .rst_n       (RESET),
                .sample_valid(samp_valid_reg),
                .sample      (samp_reg[gi]),
                .state       (st[gi]),
                .cycles      (cyc[gi]),
                .seq_err     (seq_p[gi]),
                .illegal_err (ill_p[gi]),
                .yel_err     (yel_p[gi])
            );
        end
    endgenerate

    assign conflict_hit = samp_valid_reg
                       && is_legal_light(samp_reg[0]) && is_legal_light(samp_reg[1])
                       && (samp_reg[0] != LIGHT_RED) && (samp_reg[1] != LIGHT_RED);

    logic unused_state;
    assign unused_state = ^st[0];

`ifdef TC_LIGHT_MONITOR_PARADE_CHECK_EN
    logic p_samp_reg, r_samp_reg, parade_mode_reg;

    // Release wins over request when both are sampled together.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            p_samp_reg      <= 1'b0;
            r_samp_reg      <= 1'b0;
            parade_mode_reg <= 1'b0;
        end else begin
            p_samp_reg <= P;
            r_samp_reg <= R;
            if (r_samp_reg)
                parade_mode_reg <= 1'b0;
            else if (p_samp_reg)
                parade_mode_reg <= 1'b1;
        end
    end

    // Only a street already held green may not leave green during a parade.
    assign parade_hit = samp_valid_reg && parade_mode_reg
                     && (st[1] == S_GREEN) && (samp_reg[1] != LIGHT_GRN);
`else
    logic unused_parade;
    assign unused_parade = ^{P, R, st[1]};
    assign parade_hit    = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            err_ill_reg  <= 1'b0;
            err_seq_reg  <= 1'b0;
            err_conf_reg <= 1'b0;
            err_yel_reg  <= 1'b0;
            err_par_reg  <= 1'b0;
        end else begin
            err_ill_reg  <= err_ill_reg  | (|ill_p);
            err_seq_reg  <= err_seq_reg  | (|seq_p);
            err_conf_reg <= err_conf_reg | conflict_hit;
            err_yel_reg  <= err_yel_reg  | (|yel_p);
            err_par_reg  <= err_par_reg  | parade_hit;
        end
    end

    assign ERR_ILLEGAL  = err_ill_reg;
    assign ERR_SEQ      = err_seq_reg;
    assign ERR_CONFLICT = err_conf_reg;
    assign ERR_YEL      = err_yel_reg;
    assign ERR_PARADE   = err_par_reg;
    assign ERR_ANY      = err_ill_reg | err_seq_reg | err_conf_reg | err_yel_reg | err_par_reg;
    assign CYCLES_A     = cyc[0];
    assign CYCLES_B     = cyc[1];

endmodule

// File: tb/tb_tc_light_monitor.sv
// Table-driven bench for tc_light_monitor; expectations queued per driven vector
// and compared once the two-edge pipeline has produced them.
module tb_tc_light_monitor;

    localparam int CNT_W = 8;
    localparam logic [2:0] GN = 3'b001;
    localparam logic [2:0] YL = 3'b010;
    localparam logic [2:0] RD = 3'b100;

    // Error bit order: {ILLEGAL, SEQ, CONFLICT, YEL, PARADE}
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_ILL  = 5'b10000;
    localparam logic [4:0] E_SEQ  = 5'b01000;
    localparam logic [4:0] E_CONF = 5'b00100;
    localparam logic [4:0] E_YEL  = 5'b00010;
`ifdef TC_LIGHT_MONITOR_PARADE_CHECK_EN
    localparam logic [4:0] E_PAR  = 5'b00001;
`else
    localparam logic [4:0] E_PAR  = 5'b00000;
`endif

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic [2:0]       L_A = RD;
    logic [2:0]       L_B = RD;
    logic             P = 1'b0;
    logic             R = 1'b0;
    logic             ERR_ILLEGAL, ERR_SEQ, ERR_CONFLICT, ERR_YEL, ERR_PARADE, ERR_ANY;
    logic [CNT_W-1:0] CYCLES_A, CYCLES_B;

    tc_light_monitor #(.YELLOW_CYCLES(5), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .L_A(L_A), .L_B(L_B), .P(P), .R(R),
        .ERR_ILLEGAL(ERR_ILLEGAL), .ERR_SEQ(ERR_SEQ), .ERR_CONFLICT(ERR_CONFLICT),
        .ERR_YEL(ERR_YEL), .ERR_PARADE(ERR_PARADE), .ERR_ANY(ERR_ANY),
        .CYCLES_A(CYCLES_A), .CYCLES_B(CYCLES_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]       la;
        logic [2:0]       lb;
        logic             p;
        logic             r;
        logic [4:0]       err;
        logic [CNT_W-1:0] ca;
        logic [CNT_W-1:0] cb;
    } vec_t;

    typedef struct {
        int               tnum;
        int               idx;
        logic [4:0]       err;
        logic [CNT_W-1:0] ca;
        logic [CNT_W-1:0] cb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   test_no = 0;

    task automatic add(input logic [2:0] la, input logic [2:0] lb, input logic p, input logic r,
                       input logic [4:0] err, input logic [CNT_W-1:0] ca,
                       input logic [CNT_W-1:0] cb, input int n);
        vec_t v;
        v.la = la; v.lb = lb; v.p = p; v.r = r; v.err = err; v.ca = ca; v.cb = cb;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input exp_t e);
        logic [5:0] got_f, want_f;
        got_f  = {ERR_ILLEGAL, ERR_SEQ, ERR_CONFLICT, ERR_YEL, ERR_PARADE, ERR_ANY};
        want_f = {e.err, |e.err};
        total++;
        if (got_f !== want_f) begin
            bad++;
            $display("FAIL flags t%0d v%0d got=%b want=%b", e.tnum, e.idx, got_f, want_f);
        end
        total++;
        if ({CYCLES_A, CYCLES_B} !== {e.ca, e.cb}) begin
            bad++;
            $display("FAIL cycles t%0d v%0d got=%0d/%0d want=%0d/%0d",
                     e.tnum, e.idx, CYCLES_A, CYCLES_B, e.ca, e.cb);
        end
        $display("t%0d v%0d flags=%b cycles=%0d/%0d", e.tnum, e.idx, got_f, CYCLES_A, CYCLES_B);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        P = 1'b0;
        R = 1'b0;
        test_no++;
        total++;
        if ({ERR_ANY, ERR_ILLEGAL, ERR_SEQ, ERR_CONFLICT, ERR_YEL, ERR_PARADE, CYCLES_A, CYCLES_B} !== '0) begin
            bad++;
            $display("FAIL reset t%0d got=%b%b%b%b%b%b %0d/%0d want=all zero", test_no,
                     ERR_ANY, ERR_ILLEGAL, ERR_SEQ, ERR_CONFLICT, ERR_YEL, ERR_PARADE, CYCLES_A, CYCLES_B);
        end
        $display("t%0d reset flags=%b cycles=%0d/%0d", test_no, ERR_ANY, CYCLES_A, CYCLES_B);
    endtask

    task automatic run_table();
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            L_A = vecs[i].la; L_B = vecs[i].lb; P = vecs[i].p; R = vecs[i].r;
            e.tnum = test_no; e.idx = i; e.err = vecs[i].err; e.ca = vecs[i].ca; e.cb = vecs[i].cb;
            sb.push_back(e);
            @(posedge CLK); #1;
            if (sb.size() > 1) check(sb.pop_front());
        end
        P = 1'b0; R = 1'b0;
        @(posedge CLK); #1;
        if (sb.size() > 0) check(sb.pop_front());
        vecs.delete();
        sb.delete();
    endtask

    initial begin
        do_reset();

        // Full normal cycle on both streets, then an illegal code while counters are non-zero.
        add(GN, RD, 0, 0, E_NONE, 0, 0, 10);
        add(YL, RD, 0, 0, E_NONE, 0, 0, 5);
        add(RD, GN, 0, 0, E_NONE, 0, 1, 10);
        add(RD, YL, 0, 0, E_NONE, 0, 1, 5);
        add(RD, RD, 0, 0, E_NONE, 0, 1, 1);
        add(GN, RD, 0, 0, E_NONE, 1, 1, 3);
        add(3'b110, RD, 0, 0, E_ILL, 1, 1, 1);
        add(GN, RD, 0, 0, E_ILL, 1, 1, 2);
        run_table();
        do_reset();

        // Conflict on an otherwise legal G->Y / R->G step.
        add(RD, GN, 0, 0, E_NONE, 0, 0, 2);
        add(GN, YL, 0, 0, E_CONF, 1, 0, 1);
        run_table();
        do_reset();

        // Yellow too short, too long, and long enough to expose saturation.
        add(GN, RD, 0, 0, E_NONE, 0, 0, 2);
        add(YL, RD, 0, 0, E_NONE, 0, 0, 4);
        add(RD, RD, 0, 0, E_YEL, 0, 0, 2);
        run_table();
        do_reset();
        add(GN, RD, 0, 0, E_NONE, 0, 0, 2);
        add(YL, RD, 0, 0, E_NONE, 0, 0, 6);
        add(RD, RD, 0, 0, E_YEL, 0, 0, 2);
        run_table();
        do_reset();
        add(GN, RD, 0, 0, E_NONE, 0, 0, 2);
        add(YL, RD, 0, 0, E_NONE, 0, 0, 21);
        add(RD, RD, 0, 0, E_YEL, 0, 0, 2);
        run_table();
        do_reset();

        // G->R skip resyncs to red so the following R->G counts.
        add(GN, RD, 0, 0, E_NONE, 0, 0, 2);
        add(RD, RD, 0, 0, E_SEQ, 0, 0, 2);
        add(GN, RD, 0, 0, E_SEQ, 1, 0, 1);
        run_table();
        do_reset();

        add(GN, RD, 0, 0, E_NONE, 0, 0, 1);
        add(GN, 3'b000, 0, 0, E_ILL, 0, 0, 1);
        run_table();
        do_reset();

        // Illegal code out of yellow latches two flags at once.
        add(GN, RD, 0, 0, E_NONE, 0, 0, 1);
        add(YL, RD, 0, 0, E_NONE, 0, 0, 3);
        add(3'b111, RD, 0, 0, E_ILL | E_YEL, 0, 0, 1);
        run_table();
        do_reset();

        // Parade: request then B leaves green.
        add(RD, GN, 0, 0, E_NONE, 0, 0, 2);
        add(RD, GN, 1, 0, E_NONE, 0, 0, 1);
        add(RD, YL, 0, 0, E_PAR, 0, 0, 1);
        run_table();
        do_reset();

        // Parade request followed by release.
        add(RD, GN, 0, 0, E_NONE, 0, 0, 2);
        add(RD, GN, 1, 0, E_NONE, 0, 0, 1);
        add(RD, GN, 0, 1, E_NONE, 0, 0, 1);
        add(RD, YL, 0, 0, E_NONE, 0, 0, 1);
        run_table();
        do_reset();

        // Request and release together leave the mode off.
        add(RD, GN, 0, 0, E_NONE, 0, 0, 2);
        add(RD, GN, 1, 1, E_NONE, 0, 0, 1);
        add(RD, YL, 0, 0, E_NONE, 0, 0, 1);
        run_table();
        do_reset();

        // B already yellow when parade starts may finish its cycle.
        add(RD, GN, 0, 0, E_NONE, 0, 0, 2);
        add(RD, YL, 1, 0, E_NONE, 0, 0, 1);
        add(RD, YL, 0, 0, E_NONE, 0, 0, 4);
        add(RD, RD, 0, 0, E_NONE, 0, 0, 2);
        run_table();

        // Illegal code present at the reset edge must leave no trace.
        L_A = 3'b000;
        L_B = 3'b000;
        do_reset();
        L_A = GN;
        L_B = RD;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            total++;
            if (ERR_ANY !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_history step%0d got=%b want=0", i, ERR_ANY);
            end
            $display("t%0d post-reset step%0d err_any=%b", test_no, i, ERR_ANY);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish got=running want=done");
        $fatal(1, "timeout");
    end

endmodule
